// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg
// Shared definitions for the fetch sequencer:
//   state_e          - fetch FSM state, 3-bit encoding
//   RESET_PC_DEFAULT - default PC loaded on reset
//   PC_STEP_DEFAULT  - default sequential increment in bytes
package pc_fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_HALTED = 3'd4
    } state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          PC_STEP_DEFAULT  = 4;

endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel
// Combinational next-PC selection.
// Priority: stall > halt > jump > branch > sequential.
// Ports:
//   pc_i            - current PC
//   stall_i         - hold PC
//   halt_i          - hold PC (fetching stops)
//   jump_i          - take jump_target_i
//   jump_target_i   - jump destination (low two bits ignored)
//   branch_taken_i  - take branch_target_i
//   branch_target_i - branch destination (low two bits ignored)
//   next_pc_o       - selected next PC, modulo 2^ADDR_W
module pc_next_sel #(
    parameter int ADDR_W  = 32,
    parameter int PC_STEP = 4
) (
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              stall_i,
    input  logic              halt_i,
    input  logic              jump_i,
    input  logic [ADDR_W-1:0] jump_target_i,
    input  logic              branch_taken_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic [ADDR_W-1:0] next_pc_o
);

    // Targets are word aligned by clearing bits [1:0].
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);

    always_comb begin
        // The add is ADDR_W bits wide, so the top of memory wraps to 0.
        next_pc_o = pc_i + STEP;
        if (stall_i || halt_i) begin
            next_pc_o = pc_i;
        end else if (jump_i) begin
            next_pc_o = jump_target_i & ALIGN_MASK;
        end else if (branch_taken_i) begin
            next_pc_o = branch_target_i & ALIGN_MASK;
        end
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
// Multi-cycle fetch controller owning the program counter. Each fetch goes
// FETCH -> (WAIT)* -> ISSUE; decode sees an instruction only on instr_valid.
// Optional feature macro: FETCH_TIMEOUT_EN (WAIT gives up after MEM_TIMEOUT
// cycles, sets sticky fetch_err and halts). Without it WAIT holds forever.
// Ports:
//   clk, rst                    - clock, synchronous active-low reset
//   stall, halt                 - hold in ISSUE / stop fetching
//   branch_taken, branch_target - taken branch and destination
//   jump, jump_target           - unconditional jump and destination
//   imem_ready                  - instruction memory data valid
//   imem_req, imem_addr         - fetch request and address (= pc_out)
//   pc_out                      - current PC
//   instr_valid                 - one pulse per issued instruction
//   instr_count                 - issued instructions, saturating
//   halted                      - high in HALTED
//   fetch_err                   - sticky fetch timeout flag
// Handshake: a fetch is outstanding while imem_req is high; the cycle in which
// imem_ready is sampled high completes it, and the instruction is issued from
// the following cycle onward (first cycle with stall low).
// Control inputs are looked at only while in ISSUE.
module pc_fetch_sequencer
    import pc_fetch_pkg::*;
#(
    parameter int              ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(RESET_PC_DEFAULT),
    parameter int              PC_STEP     = PC_STEP_DEFAULT,
    parameter int              MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              halt,
    input  logic              imem_ready,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [ADDR_W-1:0] pc_out,
    output logic              instr_valid,
    output logic [31:0]       instr_count,
    output logic              halted,
    output logic              fetch_err
);

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [31:0]       count_q;
    logic              req_q;
    logic              halted_q;

`ifdef FETCH_TIMEOUT_EN
    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_q;
    logic             err_q;
`endif

    pc_next_sel #(
        .ADDR_W (ADDR_W),
        .PC_STEP(PC_STEP)
    ) u_next_sel (
        .pc_i           (pc_q),
        .stall_i        (stall),
        .halt_i         (halt),
        .jump_i         (jump),
        .jump_target_i  (jump_target),
        .branch_taken_i (branch_taken),
        .branch_target_i(branch_target),
        .next_pc_o      (pc_d)
    );

    // imem_req and halted are registered alongside the state they decode.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            count_q  <= 32'd0;
            req_q    <= 1'b0;
            halted_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            tmo_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_FETCH;
                    req_q   <= 1'b1;
                end
                ST_FETCH: begin
                    if (imem_ready) begin
                        state_q <= ST_ISSUE;
                        req_q   <= 1'b0;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_ready) begin
                        state_q <= ST_ISSUE;
                        req_q   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
                        tmo_q   <= '0;
`endif
                    end
`ifdef FETCH_TIMEOUT_EN
                    // Last allowed WAIT cycle passed without data: abandon it.
                    else if (tmo_q == TMO_W'(MEM_TIMEOUT - 1)) begin
                        state_q  <= ST_HALTED;
                        req_q    <= 1'b0;
                        halted_q <= 1'b1;
                        err_q    <= 1'b1;
                        tmo_q    <= '0;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
`endif
                end
                ST_ISSUE: begin
                    if (!stall) begin
                        if (count_q != 32'hFFFF_FFFF) begin
                            count_q <= count_q + 32'd1;
                        end
                        // pc_d already holds the PC when halt is set.
                        pc_q <= pc_d;
                        if (halt) begin
                            state_q  <= ST_HALTED;
                            halted_q <= 1'b1;
                        end else begin
                            state_q <= ST_FETCH;
                            req_q   <= 1'b1;
                        end
                    end
                end
                ST_HALTED: begin
                    state_q <= ST_HALTED;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    req_q    <= 1'b0;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    // instr_valid must drop in the same cycle stall rises, so it is decoded
    // from the state and the live stall input rather than registered.
    assign instr_valid = (state_q == ST_ISSUE) && !stall;
    assign imem_req    = req_q;
    assign halted      = halted_q;
    assign pc_out      = pc_q;
    assign imem_addr   = pc_q;
    assign instr_count = count_q;

`ifdef FETCH_TIMEOUT_EN
    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
module tb_pc_fetch_sequencer;

    localparam int MEM_TIMEOUT = 15;
    localparam int PH_START = 0;  // first cycle after reset, no request yet
    localparam int PH_MEM   = 1;  // waiting for memory to answer
    localparam int PH_OFFER = 2;  // instruction available, issues when unstalled
    localparam int PH_STOP  = 3;  // halted

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = 32'd0;
    logic        halt = 1'b0;
    logic        imem_ready = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic [31:0] instr_count;
    logic        halted;
    logic        fetch_err;

    pc_fetch_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .halt         (halt),
        .imem_ready   (imem_ready),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .pc_out       (pc_out),
        .instr_valid  (instr_valid),
        .instr_count  (instr_count),
        .halted       (halted),
        .fetch_err    (fetch_err)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard / reference model ----------------
    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    int          m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_count;
    logic        m_err;
    int          m_mem_cycles;
    int          obs_req_cycles;
    int          obs_valid_cycles;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] aligned(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    task automatic model_step();
        case (m_phase)
            PH_START: begin
                m_phase      = PH_MEM;
                m_mem_cycles = 0;
            end
            PH_MEM: begin
                if (imem_ready) begin
                    m_phase = PH_OFFER;
                end else begin
                    m_mem_cycles++;
`ifdef FETCH_TIMEOUT_EN
                    // one FETCH cycle plus MEM_TIMEOUT WAIT cycles
                    if (m_mem_cycles == 1 + MEM_TIMEOUT) begin
                        m_phase = PH_STOP;
                        m_err   = 1'b1;
                    end
`endif
                end
            end
            PH_OFFER: begin
                if (!stall) begin
                    if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
                    if (halt) begin
                        m_phase = PH_STOP;
                    end else begin
                        if (jump)              m_pc = aligned(jump_target);
                        else if (branch_taken) m_pc = aligned(branch_target);
                        else                   m_pc = m_pc + 32'd4;
                        m_phase      = PH_MEM;
                        m_mem_cycles = 0;
                    end
                end
            end
            default: ;
        endcase
    endtask

    // Inputs for this cycle are already driven; sample, advance model, move on.
    task automatic tick();
        logic exp_valid;
        #1;
        exp_valid = (m_phase == PH_OFFER) && !stall;
        check("instr_valid", 32'(instr_valid), 32'(exp_valid));
        check("imem_req", 32'(imem_req), 32'(m_phase == PH_MEM));
        check("halted", 32'(halted), 32'(m_phase == PH_STOP));
        check("pc_out", pc_out, m_pc);
        check("imem_addr", imem_addr, m_pc);
        check("instr_count", instr_count, m_count);
        check("fetch_err", 32'(fetch_err), 32'(m_err));
        if (exp_valid) exp_q.push_back(m_pc);
        if (instr_valid) begin
            obs_valid_cycles++;
            if (exp_q.size() == 0) check("unexpected_issue", 32'd1, 32'd0);
            else                   check("issue_pc", pc_out, exp_q.pop_front());
        end
        if (imem_req) obs_req_cycles++;
        model_step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_junk(input logic ready);
        imem_ready    = ready;
        stall         = 1'($urandom_range(0, 1));
        halt          = 1'($urandom_range(0, 1));
        jump          = 1'($urandom_range(0, 1));
        branch_taken  = 1'($urandom_range(0, 1));
        jump_target   = $urandom;
        branch_target = $urandom;
    endtask

    task automatic do_reset();
        drive_junk(1'($urandom_range(0, 1)));
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_phase = PH_START;
        m_pc    = 32'd0;
        m_count = 32'd0;
        m_err   = 1'b0;
        m_mem_cycles = 0;
        exp_q.delete();
        check("rst_pc_out", pc_out, 32'd0);
        check("rst_instr_count", instr_count, 32'd0);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_fetch_err", 32'(fetch_err), 32'd0);
    endtask

    // One instruction: memory answers after 'delay' low cycles, issue is
    // stalled 'nstall' cycles, then taken with the given controls.
    task automatic issue_one(input int delay, input int nstall, input logic h,
                             input logic j, input logic [31:0] jt,
                             input logic b, input logic [31:0] bt);
        int k;
        obs_req_cycles   = 0;
        obs_valid_cycles = 0;
        k = 0;
        while ((m_phase == PH_START || m_phase == PH_MEM) && k < 1000) begin
            drive_junk((m_phase == PH_MEM) && (k >= delay));
            if (m_phase == PH_MEM) k++;
            tick();
        end
        for (int s = 0; s < nstall && m_phase == PH_OFFER; s++) begin
            drive_junk(1'($urandom_range(0, 1)));
            stall = 1'b1;
            tick();
        end
        if (m_phase == PH_OFFER) begin
            imem_ready    = 1'($urandom_range(0, 1));
            stall         = 1'b0;
            halt          = h;
            jump          = j;
            jump_target   = jt;
            branch_taken  = b;
            branch_target = bt;
            tick();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int d;
        int s;
        int r;
        do_reset();

        // sequential fetch with memory always ready
        issue_one(0, 0, 0, 0, 32'd0, 0, 32'd0);
        issue_one(0, 0, 0, 0, 32'd0, 0, 32'd0);
        check("pc_before_branch", pc_out, 32'h8);
        issue_one(0, 0, 0, 0, 32'd0, 1, 32'h0000_0043);
        check("branch_aligned_addr", imem_addr, 32'h40);
        issue_one(0, 0, 0, 1, 32'h100, 1, 32'h200);
        check("jump_over_branch_addr", imem_addr, 32'h100);
        check("count_after_4", instr_count, 32'd4);

        // three WAIT cycles, then three stalled ISSUE cycles
        issue_one(3, 3, 0, 0, 32'd0, 0, 32'd0);
        check("wait_req_cycles", 32'(obs_req_cycles), 32'd4);
        check("stall_single_pulse", 32'(obs_valid_cycles), 32'd1);

        // wrap at the top of the address space
        issue_one(0, 0, 0, 0, 32'd0, 1, 32'hFFFF_FFFF);
        check("pc_top", pc_out, 32'hFFFF_FFFC);
        issue_one(1, 0, 0, 0, 32'd0, 0, 32'd0);
        check("pc_wrap", pc_out, 32'd0);

        // halt at 0x10, stays halted until reset
        issue_one(0, 0, 0, 1, 32'h12, 0, 32'd0);
        issue_one(2, 1, 1, 1, 32'h300, 1, 32'h400);
        check("halt_flag", 32'(halted), 32'd1);
        for (int i = 0; i < 10; i++) begin
            drive_junk(1'($urandom_range(0, 1)));
            tick();
        end
        check("halt_pc", pc_out, 32'h10);
        check("halt_no_req", 32'(imem_req), 32'd0);
        do_reset();

        // reset in the middle of WAIT
        for (int i = 0; i < 4; i++) begin
            drive_junk(1'b0);
            tick();
        end
        check("in_wait_req", 32'(imem_req), 32'd1);
        do_reset();

        // randomized traffic
        for (int n = 0; n < 250; n++) begin
            d = $urandom_range(0, 3);
            s = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            r = $urandom_range(0, 9);
            issue_one(d, s, 0, (r == 0), $urandom, (r >= 7), $urandom);
        end

        // memory never answers for 100 cycles
        issue_one(0, 0, 0, 0, 32'd0, 0, 32'd0);
        for (int i = 0; i < 100; i++) begin
            drive_junk(1'b0);
            tick();
        end
`ifdef FETCH_TIMEOUT_EN
        check("timeout_err", 32'(fetch_err), 32'd1);
        check("timeout_halted", 32'(halted), 32'd1);
`else
        check("no_timeout_err", 32'(fetch_err), 32'd0);
        check("no_timeout_req", 32'(imem_req), 32'd1);
`endif
        do_reset();
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
